imsic_eip_file: RTL and testbench

- One IMSIC interrupt file for one hart and one privilege level. Sits directly downstream of the IMSIC MMIO register map and consumes its per-file setipnum/we pair.
- Holds the pending (eip) and enable (eie) bit arrays plus the eidelivery and eithreshold registers.
- Computes a registered top interrupt identity (topei) and the xEIP line toward the hart.
- Exposes a word-indexed CSR access port and a claim handshake to the hart's CSR logic.

---
 rtl/imsic_pkg.sv | 18 +
 rtl/imsic_topei_search.sv | 27 ++
 rtl/imsic_eip_file.sv | 127 ++++++++++++
 tb/tb_imsic_eip_file.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imsic_pkg.sv
// Shared definitions for IMSIC interrupt files: CSR select encoding,
// default identity type and drop-counter width.
package imsic_pkg;

  typedef enum logic [1:0] {
    EIDELIVERY  = 2'd0,
    EITHRESHOLD = 2'd1,
    EIP         = 2'd2,
    EIE         = 2'd3
  } reg_sel_e;

  localparam int unsigned NR_SOURCES_DFLT = 64;
  localparam int unsigned ID_W            = $clog2(NR_SOURCES_DFLT);
  typedef logic [ID_W-1:0] id_t;

  localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/imsic_topei_search.sv
// Lowest-index pending-and-enabled priority encoder with threshold mask.
// Identity 0 never qualifies; threshold 0 disables masking.
module imsic_topei_search #(
  parameter int unsigned NrSources  = 64,
  parameter int unsigned NrSourcesW = $clog2(NrSources)
) (
  input  logic [NrSources-1:0]  pending,
  input  logic [NrSources-1:0]  enable,
  input  logic [NrSourcesW-1:0] threshold,
  output logic [NrSourcesW-1:0] top_id
);

  logic [NrSources-1:0] cand;

  // Scan downward so the last hit, the lowest qualifying id, wins.
  always_comb begin
    cand    = pending & enable;
    cand[0] = 1'b0;
    top_id  = '0;
    for (int i = NrSources - 1; i > 0; i--) begin
      if (cand[i] && ((threshold == '0) || (i < int'(threshold)))) begin
        top_id = NrSourcesW'(i);
      end
    end
  end

endmodule

// File: rtl/imsic_eip_file.sv
// One IMSIC interrupt file: eip/eie arrays, eidelivery, eithreshold, topei/xEIP.
// Optional dropped-MSI counter enabled by defining IMSIC_EIP_FILE_DROP_CNT_EN.
module imsic_eip_file
  import imsic_pkg::*;
#(
  parameter int unsigned NrSources  = NR_SOURCES_DFLT,
  parameter int unsigned NrSourcesW = $clog2(NrSources),
  parameter int unsigned NrWords    = NrSources / 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NrSourcesW-1:0]      i_setipnum,
  input  logic                       i_setipnum_we,
  input  logic                       i_reg_en,
  input  logic                       i_reg_we,
  input  logic [1:0]                 i_reg_sel,
  input  logic [$clog2(NrWords)-1:0] i_reg_idx,
  input  logic [31:0]                i_reg_wdata,
  output logic [31:0]                o_reg_rdata,
  input  logic                       i_claim,
  output logic [NrSourcesW-1:0]      o_topei,
  output logic                       o_xeip,
  output logic [DROP_CNT_W-1:0]      o_drop_cnt
);

  logic [NrSources-1:0]  eip, eie;
  logic                  eidelivery;
  logic [NrSourcesW-1:0] eithreshold;

  reg_sel_e              sel;
  logic                  wr, wr_del, wr_thr, wr_eip, wr_eie;
  logic                  set_ok, claim_ok, thr_blk;
  logic [NrSources-1:0]  eip_csr, eip_kept, set_bit, eip_next, eie_next;
  logic [NrSourcesW-1:0] top_id_p0;
  logic [31:0]           rd_word;

  assign sel    = reg_sel_e'(i_reg_sel);
  assign wr     = i_reg_en && i_reg_we;
  assign wr_del = wr && (sel == EIDELIVERY);
  assign wr_thr = wr && (sel == EITHRESHOLD);
  assign wr_eip = wr && (sel == EIP);
  assign wr_eie = wr && (sel == EIE);

  assign set_ok   = i_setipnum_we && (i_setipnum != '0) && (32'(i_setipnum) < NrSources);
  assign claim_ok = i_claim && (o_topei != '0);

  // CSR write first, then claim clear, then MSI set so a set always wins.
  always_comb begin
    eip_csr  = eip;
    eie_next = eie;
    if (wr_eip) eip_csr[{i_reg_idx, 5'd0} +: 32] = i_reg_wdata;
    if (wr_eie) eie_next[{i_reg_idx, 5'd0} +: 32] = i_reg_wdata;
    eie_next[0] = 1'b0;
    eip_kept = eip_csr;
    if (claim_ok) eip_kept[o_topei] = 1'b0;
    set_bit = '0;
    if (set_ok) set_bit[i_setipnum] = 1'b1;
    eip_next    = eip_kept | set_bit;
    eip_next[0] = 1'b0;
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      EIDELIVERY:  rd_word[0] = eidelivery;
      EITHRESHOLD: rd_word[NrSourcesW-1:0] = eithreshold;
      EIP:         rd_word = eip[{i_reg_idx, 5'd0} +: 32];
      EIE:         rd_word = eie[{i_reg_idx, 5'd0} +: 32];
      default:     rd_word = '0;
    endcase
  end

  imsic_topei_search #(
    .NrSources  (NrSources),
    .NrSourcesW (NrSourcesW)
  ) u_search (
    .pending   (eip),
    .enable    (eie),
    .threshold (eithreshold),
    .top_id    (top_id_p0)
  );

`ifdef IMSIC_EIP_FILE_DROP_CNT_EN
  logic                  drop, cnt_clr;
  logic [DROP_CNT_W-1:0] drop_cnt;

  // "Already pending" is judged after claim and CSR clears of this cycle.
  assign drop    = i_setipnum_we && (!set_ok || eip_kept[i_setipnum]);
  assign cnt_clr = wr_thr && i_reg_wdata[31];
  assign thr_blk = cnt_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst || cnt_clr) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign o_drop_cnt = drop_cnt;
`else
  assign thr_blk    = 1'b0;
  assign o_drop_cnt = '0;
`endif

  // p0 -> p1: search result and xEIP registered together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      eip         <= '0;
      eie         <= '0;
      eidelivery  <= 1'b0;
      eithreshold <= '0;
      o_reg_rdata <= '0;
      o_topei     <= '0;
      o_xeip      <= 1'b0;
    end else begin
      eip <= eip_next;
      eie <= eie_next;
      if (wr_del) eidelivery <= i_reg_wdata[0];
      if (wr_thr && !thr_blk) eithreshold <= i_reg_wdata[NrSourcesW-1:0];
      if (i_reg_en && !i_reg_we) o_reg_rdata <= rd_word;
      o_topei <= top_id_p0;
      o_xeip  <= eidelivery && (top_id_p0 != '0);
    end
  end

endmodule

// File: tb/tb_imsic_eip_file.sv
// Scoreboard bench for imsic_eip_file: expectations queued at stimulus time,
// popped and compared when the DUT output is sampled.
module tb_imsic_eip_file;
  import imsic_pkg::*;

  localparam int unsigned NrSources  = 64;
  localparam int unsigned NrSourcesW = $clog2(NrSources);
  localparam int unsigned NrWords    = NrSources / 32;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [NrSourcesW-1:0]      setipnum = '0;
  logic                       setipnum_we = 1'b0;
  logic                       reg_en = 1'b0;
  logic                       reg_we = 1'b0;
  logic [1:0]                 reg_sel = '0;
  logic [$clog2(NrWords)-1:0] reg_idx = '0;
  logic [31:0]                reg_wdata = '0;
  logic [31:0]                reg_rdata;
  logic                       claim = 1'b0;
  logic [NrSourcesW-1:0]      topei;
  logic                       xeip;
  logic [DROP_CNT_W-1:0]      drop_cnt;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  imsic_eip_file #(.NrSources(NrSources)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_setipnum    (setipnum),
    .i_setipnum_we (setipnum_we),
    .i_reg_en      (reg_en),
    .i_reg_we      (reg_we),
    .i_reg_sel     (reg_sel),
    .i_reg_idx     (reg_idx),
    .i_reg_wdata   (reg_wdata),
    .o_reg_rdata   (reg_rdata),
    .i_claim       (claim),
    .o_topei       (topei),
    .o_xeip        (xeip),
    .o_drop_cnt    (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic csr_write(input logic [1:0] sel, input int idx, input logic [31:0] d);
    reg_en = 1'b1; reg_we = 1'b1; reg_sel = sel;
    reg_idx = idx[$clog2(NrWords)-1:0]; reg_wdata = d;
    tick();
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] sel, input int idx, output logic [31:0] d);
    reg_en = 1'b1; reg_we = 1'b0; reg_sel = sel;
    reg_idx = idx[$clog2(NrWords)-1:0];
    tick();
    reg_en = 1'b0;
    d = reg_rdata;
  endtask

  task automatic set_id(input int id);
    setipnum = NrSourcesW'(id); setipnum_we = 1'b1;
    tick();
    setipnum_we = 1'b0;
  endtask

  task automatic do_claim();
    claim = 1'b1;
    tick();
    claim = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] got;
    do_reset();
    exp_q.push_back('{name:"rst_topei", val:32'd0});
    exp_q.push_back('{name:"rst_xeip", val:32'd0});
    exp_q.push_back('{name:"rst_rdata", val:32'd0});
    exp_q.push_back('{name:"rst_drop", val:32'd0});
    got = 32'(topei); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    got = 32'(xeip); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    got = reg_rdata; e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    got = 32'(drop_cnt); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back('{name:$sformatf("rst_read_sel%0d", s), val:32'd0});
      csr_read(2'(s), 0, got);
      e = exp_q.pop_front(); tests_run++;
      if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_basic();
    exp_t e; logic [31:0] got;
    do_reset();
    csr_write(EIE, 0, 32'h20);
    csr_write(EIDELIVERY, 0, 32'h1);
    exp_q.push_back('{name:"basic_topei_same_edge", val:32'd0});
    exp_q.push_back('{name:"basic_topei_next", val:32'd5});
    exp_q.push_back('{name:"basic_xeip_next", val:32'd1});
    set_id(5);
    got = 32'(topei); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    tick();
    got = 32'(topei); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    got = 32'(xeip); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    exp_q.push_back('{name:"basic_eip_w0", val:32'h20});
    csr_read(EIP, 0, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_priority_claim();
    exp_t e; logic [31:0] got;
    do_reset();
    csr_write(EIE, 0, 32'h208);
    csr_write(EIDELIVERY, 0, 32'h1);
    set_id(9);
    set_id(3);
    exp_q.push_back('{name:"prio_topei_3", val:32'd3});
    tick();
    got = 32'(topei); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    exp_q.push_back('{name:"prio_topei_9", val:32'd9});
    do_claim();
    tick();
    got = 32'(topei); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    exp_q.push_back('{name:"prio_topei_0", val:32'd0});
    exp_q.push_back('{name:"prio_xeip_0", val:32'd0});
    do_claim();
    tick();
    got = 32'(topei); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    got = 32'(xeip); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_threshold();
    exp_t e; logic [31:0] got;
    logic [31:0] thr_seq [3] = '{32'd8, 32'd3, 32'd0};
    logic [31:0] top_exp [3] = '{32'd3, 32'd0, 32'd3};
    do_reset();
    csr_write(EIE, 0, 32'h208);
    csr_write(EIDELIVERY, 0, 32'h1);
    set_id(3);
    set_id(9);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{name:$sformatf("thr%0d_topei", thr_seq[k]), val:top_exp[k]});
      exp_q.push_back('{name:$sformatf("thr%0d_xeip", thr_seq[k]), val:32'(top_exp[k] != 0)});
      csr_write(EITHRESHOLD, 0, thr_seq[k]);
      tick();
      got = 32'(topei); e = exp_q.pop_front(); tests_run++;
      if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
      got = 32'(xeip); e = exp_q.pop_front(); tests_run++;
      if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    end
    set_id(40);
    exp_q.push_back('{name:"hi_word_eip_w1", val:32'h100});
    csr_read(EIP, 1, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_regs();
    exp_t e; logic [31:0] got;
    logic [1:0]  sel_t [4] = '{EIE, EIDELIVERY, EITHRESHOLD, EIP};
    logic [31:0] wr_t  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001};
    logic [31:0] rd_t  [4] = '{32'hFFFF_FFFE, 32'h1, 32'h3F, 32'h0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{name:$sformatf("reg_rw_sel%0d", sel_t[k]), val:rd_t[k]});
      csr_write(sel_t[k], 0, wr_t[k]);
      csr_read(sel_t[k], 0, got);
      e = exp_q.pop_front(); tests_run++;
      if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    end
    exp_q.push_back('{name:"rdata_hold", val:32'h0});
    csr_write(EIE, 0, 32'h0);
    tick();
    got = reg_rdata; e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_collision();
    exp_t e; logic [31:0] got;
    do_reset();
    csr_write(EIE, 0, 32'h80);
    csr_write(EIDELIVERY, 0, 32'h1);
    set_id(7);
    tick();
    exp_q.push_back('{name:"claim_vs_set_topei", val:32'd7});
    claim = 1'b1; setipnum = NrSourcesW'(7); setipnum_we = 1'b1;
    tick();
    claim = 1'b0; setipnum_we = 1'b0;
    tick();
    got = 32'(topei); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    exp_q.push_back('{name:"claim_vs_set_eip", val:32'h80});
    csr_read(EIP, 0, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    exp_q.push_back('{name:"csrclr_vs_set_eip", val:32'h80});
    reg_en = 1'b1; reg_we = 1'b1; reg_sel = EIP; reg_idx = '0; reg_wdata = 32'h0;
    setipnum = NrSourcesW'(7); setipnum_we = 1'b1;
    tick();
    reg_en = 1'b0; reg_we = 1'b0; setipnum_we = 1'b0;
    csr_read(EIP, 0, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    exp_q.push_back('{name:"csrclr_eip", val:32'h0});
    csr_write(EIP, 0, 32'h0);
    csr_read(EIP, 0, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_drop();
    exp_t e; logic [31:0] got;
    logic [31:0] exp_cnt, exp_thr;
`ifdef IMSIC_EIP_FILE_DROP_CNT_EN
    exp_cnt = 32'd3; exp_thr = 32'd0;
`else
    exp_cnt = 32'd0; exp_thr = 32'd5;
`endif
    do_reset();
    exp_q.push_back('{name:"drop_eip_w0", val:32'h10});
    exp_q.push_back('{name:"drop_cnt", val:exp_cnt});
    set_id(0);
    set_id(64);
    set_id(4);
    set_id(4);
    csr_read(EIP, 0, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    got = 32'(drop_cnt); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    exp_q.push_back('{name:"drop_cnt_clr", val:32'd0});
    exp_q.push_back('{name:"drop_clr_thr", val:exp_thr});
    csr_write(EITHRESHOLD, 0, 32'h8000_0005);
    got = 32'(drop_cnt); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    csr_read(EITHRESHOLD, 0, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [31:0] got;
    do_reset();
    exp_q.push_back('{name:"b2b_eip_w1", val:32'h0000_000E});
    for (int id = 33; id <= 35; id++) begin
      setipnum = NrSourcesW'(id); setipnum_we = 1'b1;
      tick();
    end
    setipnum_we = 1'b0;
    csr_read(EIP, 1, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [31:0] got;
    do_reset();
    csr_write(EIE, 0, 32'h248);
    csr_write(EIDELIVERY, 0, 32'h1);
    csr_write(EITHRESHOLD, 0, 32'd20);
    set_id(3);
    set_id(9);
    tick();
    exp_q.push_back('{name:"midrst_topei", val:32'd0});
    exp_q.push_back('{name:"midrst_xeip", val:32'd0});
    exp_q.push_back('{name:"midrst_topei_next", val:32'd0});
    rst = 1'b1; setipnum = NrSourcesW'(6); setipnum_we = 1'b1;
    tick();
    rst = 1'b0; setipnum_we = 1'b0;
    got = 32'(topei); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    got = 32'(xeip); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    tick();
    got = 32'(topei); e = exp_q.pop_front(); tests_run++;
    if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back('{name:$sformatf("midrst_read_sel%0d", s), val:32'd0});
      csr_read(2'(s), 0, got);
      e = exp_q.pop_front(); tests_run++;
      if (got !== e.val) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_basic();
    test_priority_claim();
    test_threshold();
    test_regs();
    test_collision();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
